// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type and counter-width helper for seq_multiplier.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-and-add MUL/MLA with start/busy/done handshake.
// Fixed WIDTH-cycle latency; only the low WIDTH bits of the product are kept.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mla,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, res_q, res_d, p_add;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             n_q, n_d, z_q, z_d;
  logic             calc, accept, last;
  always_comb begin
    calc    = state_q == CALC;
    accept  = start && !calc;
    last    = calc && cnt_q == CNT_MAX;
    p_add   = p_q + (b_q[0] ? a_q : '0);
    state_d = calc ? (last ? DONE : CALC) : (start ? CALC : IDLE);
    a_d     = accept ? op_a : calc ? a_q << 1 : a_q;
    b_d     = accept ? op_b : calc ? b_q >> 1 : b_q;
    p_d     = accept ? (mla ? acc : '0) : calc ? p_add : p_q;
    cnt_d   = accept ? '0 : calc ? cnt_q + CNT_W'(1) : cnt_q;
    res_d   = last ? p_add : res_q;
    n_d     = last ? p_add[WIDTH-1] : n_q;
    z_d     = last ? p_add == '0 : z_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end
  assign busy   = state_q == CALC;
  assign done   = state_q == DONE;
  assign result = res_q;
  assign flag_n = n_q;
  assign flag_z = z_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for seq_multiplier (results, flags, latency, handshake, abort).
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst_n, start, mla;
  logic [31:0] op_a, op_b, acc, result;
  logic        busy, done, flag_n, flag_z;
  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];
  logic [33:0] last_exp;
  seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mla(mla), .op_a(op_a), .op_b(op_b),
    .acc(acc), .busy(busy), .done(done), .result(result), .flag_n(flag_n), .flag_z(flag_z)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] model(input logic [31:0] a, b, c, input logic m);
    logic [63:0] full;
    logic [31:0] p;
    full = 64'(a) * 64'(b);
    p = full[31:0] + (m ? c : 32'd0);
    return {p[31], p == 32'd0, p};
  endfunction
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_done", 1, 0);
      else chk("result_flags", {flag_n, flag_z, result}, exp_q.pop_front());
    end
  end
  task automatic rand_inputs();
    op_a = $urandom; op_b = $urandom; acc = $urandom; mla = 1'($urandom);
  endtask
  // Counts busy cycles and the negedge index of done after the accepting edge.
  task automatic wait_done(input bit poke, output int bc, output int dat);
    bc = 0; dat = 0;
    for (int n = 1; n <= 40 && dat == 0; n++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dat = n;
      if (busy && done) chk("busy_and_done", 1, 0);
      if (poke && n == 5) begin start = 1'b1; rand_inputs(); end
      if (poke && n == 6) start = 1'b0;
    end
  endtask
  task automatic launch(input logic [31:0] a, b, c, input logic m);
    start = 1'b1; op_a = a; op_b = b; acc = c; mla = m;
    last_exp = model(a, b, c, m);
    exp_q.push_back(last_exp);
  endtask
  task automatic run_op(input logic [31:0] a, b, c, input logic m, input bit poke);
    int bc, dat;
    @(posedge clk); #1;
    launch(a, b, c, m);
    @(posedge clk); #1;
    start = 1'b0; rand_inputs();
    wait_done(poke, bc, dat);
    chk("busy_cycles", bc, 32);
    chk("done_latency", dat, 33);
  endtask
  initial begin
    int bc, dat;
    rst_n = 1'b0; start = 1'($urandom); rand_inputs();
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_result", result, 0);
    chk("rst_flag_n", flag_n, 0); chk("rst_flag_z", flag_z, 0);
    repeat (3) @(negedge clk);
    chk("rst_hold", {busy, done, flag_n, flag_z, result}, 0);
    start = 1'b0; rst_n = 1'b1;
    run_op(32'd7, 32'd6, 32'd99, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd3, 32'd5, 1'b1, 1'b0);
    run_op(32'h0001_0000, 32'h0000_8000, 32'd0, 1'b0, 1'b0);
    run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h9ABC_DEF1, 32'h1111_1111, 1'b1, 1'b1);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 0);
    repeat (4) @(negedge clk);
    chk("result_hold", {flag_n, flag_z, result}, last_exp);
    // Back-to-back: start asserted during the DONE cycle.
    run_op(32'hDEAD_BEEF, 32'h0000_0101, 32'd0, 1'b0, 1'b0);
    launch(32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1);
    @(posedge clk); #1;
    start = 1'b0; rand_inputs();
    wait_done(1'b0, bc, dat);
    chk("b2b_busy", bc, 32);
    chk("b2b_gap", dat, 33);
    // Abort in the 10th CALC cycle.
    @(posedge clk); #1;
    start = 1'b1; op_a = 32'h1234; op_b = 32'h10; mla = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, flag_n, flag_z, result}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, $urandom, 1'($urandom), 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative radix-2 shift-and-add multiplier for the processor's execute stage, implementing MUL and MLA. It sits directly downstream of `shifter`. When `mul=1`, the shifter passes `rd2` through unmodified as `data`, and that value arrives here as `op_a`. The block produces the low WIDTH bits of `op_a*op_b` (+`acc` for MLA) plus N/Z flags, using a start/busy/done handshake with the decode/control FSM.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; power of two, ≥4.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation; sampled only in IDLE or DONE.
- `mla` in 1: 1 = multiply-accumulate, 0 = plain multiply; sampled with `start`.
- `op_a` in WIDTH: multiplicand (shifter `data` output); sampled with `start`.
- `op_b` in WIDTH: multiplier (Rs); sampled with `start`.
- `acc` in WIDTH: addend (Ra) for MLA; sampled with `start`, ignored when `mla=0`.
- `busy` out 1: high while an operation is iterating.
- `done` out 1: one-cycle pulse when `result` is updated.
- `result` out WIDTH: registered product; holds until the next completion.
- `flag_n` out 1: `result[WIDTH-1]`, registered with `result`.
- `flag_z` out 1: `result==0`, registered with `result`.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `start=1` at edge k: latch `op_a`→A, `op_b`→B.
  - Product reg P ← `acc` if `mla` else 0.
  - Counter ← 0; go to CALC.
  - `start=0`: stay in IDLE.
- **CALC**, each edge:
  - If B[0], P ← P + A (mod 2^WIDTH).
  - A ← A<<1; B ← B>>1; counter++.
  - At the edge with counter==WIDTH−1, perform the final step, write P into `result`/flags, and go to DONE.
  - `start` is ignored throughout CALC; operand inputs may change freely.
- **DONE** (one cycle): `done=1`.
  - `start=1` at that edge: accept as in IDLE, go directly to CALC.
  - Otherwise go to IDLE.
- Arithmetic:
  - Only the low WIDTH bits are kept.
  - Signed and unsigned operands give identical results.
  - Accumulation overflow wraps silently.
- No early termination. Latency is fixed regardless of operand values.

## Timing
- Reset (async, immediate on `rst_n` low):
  - state=IDLE; `busy`=0, `done`=0, `result`=0, `flag_n`=0, `flag_z`=0.
  - A, B, P and counter are cleared.
- Reset mid-CALC: the operation is aborted. No `done` pulse and no `result` update. The first edge after `rst_n` rises behaves as IDLE.
- `busy` is high for exactly the WIDTH cycles following the start edge.
- `done`, `result` and flags update at start edge + WIDTH. `done` is high in the cycle after that edge.
- Back-to-back operations: a start accepted in the DONE cycle gives the next `done` exactly WIDTH+1 cycles after the previous one.
- `busy` and `done` are never high together.
- `busy` and `done` are decoded from the registered state; no combinational path from inputs to outputs.

## Structure
- Shared package `mul_pkg`:
  - `mul_state_t` enum {IDLE, CALC, DONE}.
  - Localparam `MUL_CNT_W = $clog2(WIDTH)` default helper.
- Single module with inline FSM and datapath; no sub-module required.
- Counter width is `$clog2(WIDTH)`.

## Test plan
1. Reset: drive `rst_n`=0 with random inputs → `busy`=0, `done`=0, `result`=0, `flag_n`=0, `flag_z`=0.
2. MUL: `op_a`=7, `op_b`=6, `mla`=0, `start` pulsed at edge k → `busy` high 32 cycles, `done` after edge k+32, `result`=0x0000002A, N=0, Z=0.
3. MLA with wrap: `op_a`=0xFFFFFFFF, `op_b`=3, `acc`=5, `mla`=1 → `result`=0x00000002, N=0, Z=0.
4. Flags:
   - 0x00010000×0x00008000 → 0x80000000, N=1.
   - 0x00010000×0x00010000 → 0x00000000, Z=1.
5. Handshake:
   - `start` pulsed mid-CALC with new operands → ignored; original result delivered.
   - `start` held in the DONE cycle → second op accepted; second `done` 33 cycles after the first.
   - `result` holds between completions.
6. Abort: `rst_n` low at the 10th CALC cycle of 0x1234×0x10 → no `done`, outputs 0. A following op 3×5 → `result`=0x0F after 32 cycles.
